serial_adder: RTL and testbench

Bit-serial adder that adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles, one bit per cycle. The single-bit datapath is built from the team's existing `Full_adder` cell (two `half_add` instances). A registered carry feeds each bit position's carry back into the next. The block sits upstream of result-consuming logic and replaces a WIDTH-wide ripple chain where area matters more than latency. It uses a start/busy/done handshake.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// master drives a request and observes the registered result; slave is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, c_in,
    input  sum, carry, busy, done
  );

  modport slave (
    input  start, a, b, c_in,
    output sum, carry, busy, done
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: {carry,sum} = a + b + c_in, one bit per clock through a
// single Full_adder cell with a registered carry loop.
module half_add (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module Full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_add u_ha0 (.i_a(i_a),  .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  half_add u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s),  .o_c(w_c1));

  assign o_c = w_c0 | w_c1;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_cy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_s_next;

  Full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_cy),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at the LSB.
  assign w_s_next = (r_s_sh >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_cy    <= bus.c_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end

        SHIFT: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_s_sh <= w_s_next;
          r_cy   <= w_fa_c;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Result registers only move on the final bit so they stay stable across later SHIFT phases.
          if (r_cnt == LAST) begin
            r_sum   <= w_s_next;
            r_carry <= w_fa_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sum   = r_sum;
  assign bus.carry = r_carry;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=1
// against a plain-arithmetic reference for a + b + c_in.
module tb_serial_adder;
  logic clk;
  logic rst_n;

  int tests;
  int fails;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return 9'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Launch one request on the 8-bit DUT; returns just after the accepting edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = c;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.c_in  = 1'($urandom);
  endtask

  // Waits (bounded) for done; reports edges from the accepting edge inclusive,
  // busy cycles seen, and whether sum/carry stayed put until completion.
  task automatic wait_done8(input int poke_at, output int edges, output int busy_n, output bit held);
    int n;
    logic [8:0] held_val;
    n        = 0;
    busy_n   = 0;
    held     = 1'b1;
    held_val = {bus8.carry, bus8.sum};
    while (bus8.done !== 1'b1 && n < 64) begin
      if (bus8.busy === 1'b1) busy_n++;
      if ({bus8.carry, bus8.sum} !== held_val) held = 1'b0;
      if (n == poke_at) begin
        bus8.a     = 8'h11;
        bus8.b     = 8'h11;
        bus8.c_in  = 1'b0;
        bus8.start = 1'b1;
      end
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      n++;
    end
    edges = n + 1;
  endtask

  initial begin
    int         edges;
    int         busy_n;
    bit         held;
    int         dones;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] exp9;
    logic [1:0] exp2;
    logic [2:0] combo;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c_in = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out8", {23'd0, bus8.carry, bus8.sum}, 32'd0);
    chk("reset_hs8",  {30'd0, bus8.busy, bus8.done}, 32'd0);
    chk("reset_out1", {26'd0, bus1.carry, bus1.sum, bus1.busy, bus1.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3C + 42
    launch8(8'h3C, 8'h42, 1'b0);
    chk("busy_after_accept", {31'd0, bus8.busy}, 32'd1);
    wait_done8(-1, edges, busy_n, held);
    chk("latency_3c42", edges, 32'd9);
    chk("busy_cycles_3c42", busy_n, 32'd8);
    chk("result_3c42", {23'd0, bus8.carry, bus8.sum}, 32'h07E);
    chk("busy_at_done", {31'd0, bus8.busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, bus8.done}, 32'd0);

    // FF + 01 overflows into carry
    launch8(8'hFF, 8'h01, 1'b0);
    wait_done8(-1, edges, busy_n, held);
    chk("held_prev_result", {31'd0, held}, 32'd1);
    chk("result_ff01", {23'd0, bus8.carry, bus8.sum}, {23'd0, model8(8'hFF, 8'h01, 1'b0)});
    chk("result_ff01_const", {23'd0, bus8.carry, bus8.sum}, 32'h100);

    // A5 + 5A + 1, with a start poked mid-SHIFT that must be ignored
    launch8(8'hA5, 8'h5A, 1'b1);
    wait_done8(3, edges, busy_n, held);
    chk("latency_ignored_start", edges, 32'd9);
    chk("result_a55a", {23'd0, bus8.carry, bus8.sum}, 32'h100);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done === 1'b1) dones++;
    end
    chk("no_extra_done", dones, 32'd0);
    chk("busy_idle_after_ignore", {31'd0, bus8.busy}, 32'd0);

    // Back-to-back: start asserted while in DONE
    launch8(8'h12, 8'h34, 1'b0);
    wait_done8(-1, edges, busy_n, held);
    chk("result_1234", {23'd0, bus8.carry, bus8.sum}, {23'd0, model8(8'h12, 8'h34, 1'b0)});
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.c_in = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    chk("b2b_busy", {30'd0, bus8.busy, bus8.done}, 32'd2);
    chk("b2b_first_held", {23'd0, bus8.carry, bus8.sum}, 32'h046);
    wait_done8(-1, edges, busy_n, held);
    chk("b2b_held_during_shift", {31'd0, held}, 32'd1);
    chk("b2b_latency", edges, 32'd9);
    chk("b2b_result", {23'd0, bus8.carry, bus8.sum}, 32'h002);

    // Randomized operands against the arithmetic model
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp9 = model8(ra, rb, rc);
      launch8(ra, rb, rc);
      wait_done8(-1, edges, busy_n, held);
      chk($sformatf("rand%0d_%h_%h_%0d", k, ra, rb, rc), {23'd0, bus8.carry, bus8.sum}, {23'd0, exp9});
      chk($sformatf("rand%0d_lat", k), edges, 32'd9);
    end

    // Make sure a nonzero result is held, then reset in the 4th SHIFT cycle
    launch8(8'h70, 8'h0F, 1'b1);
    wait_done8(-1, edges, busy_n, held);
    chk("pre_reset_result", {23'd0, bus8.carry, bus8.sum}, 32'h080);
    launch8(8'hC3, 8'h3C, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", {23'd0, bus8.carry, bus8.sum}, 32'd0);
    chk("async_reset_hs", {30'd0, bus8.busy, bus8.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
    end
    chk("no_done_after_abort", dones, 32'd0);

    // WIDTH=1: full-adder truth table
    for (int i = 0; i < 8; i++) begin
      int n;
      combo = 3'(i);
      exp2 = 2'(int'(combo[2]) + int'(combo[1]) + int'(combo[0]));
      @(negedge clk);
      bus1.a = combo[2]; bus1.b = combo[1]; bus1.c_in = combo[0]; bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      n = 0;
      while (bus1.done !== 1'b1 && n < 16) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("w1_lat_%0d", i), n + 1, 32'd2);
      chk($sformatf("w1_fa_%0d", i), {30'd0, bus1.carry, bus1.sum}, {30'd0, exp2});
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
